color_measure: RTL

COLOR_MEASURE -- requirements
Module: color_measure

---
 rtl/color_pkg.sv | 27 ++
 rtl/freq_edge_sync.sv | 50 +++++
 rtl/color_measure.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// color_pkg: shared definitions for the colour measurement block.
//   FILT_R / FILT_G / FILT_B : sensor filter select codes
//   state_t                  : measurement sequencer states
//   sat_inc()                : 8-bit saturating increment used by the pulse counter
package color_pkg;

  localparam logic [1:0] FILT_R = 2'b00;
  localparam logic [1:0] FILT_G = 2'b11;
  localparam logic [1:0] FILT_B = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SET_R,
    CNT_R,
    SET_G,
    CNT_G,
    SET_B,
    CNT_B,
    DONE
  } state_t;

  // Adds one when inc is set, but sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// freq_edge_sync: brings the asynchronous sensor pulse train into the clk
// domain and produces a one-cycle pulse per rising edge.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   freq       : raw sensor output (asynchronous)
//   rise_pulse : one clk-cycle pulse for each synchronized rising edge
// SYNC_STAGES is the synchronizer depth; it must be at least 2.
module freq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freq,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= freq;
        end
      end else begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Registered edge detect on the last synchronizer stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign rise_pulse = rise_reg;

endmodule

// File: rtl/color_measure.sv
// color_measure: measures red, green and blue intensity from a light-to-
// frequency sensor by counting sensor pulses over calibrated windows.
//   clk, rst_n              : clock, asynchronous active-low reset
//   freq                    : sensor pulse output (asynchronous)
//   wb_ready                : calibration done; R/G/B_time valid while high
//   R_time, G_time, B_time  : per-channel counting window in clk cycles
//   start                   : one-cycle request for a measurement
//   filter_select           : sensor filter code for the active channel
//   red, green, blue        : last completed measurement (saturating at 255)
//   rgb_valid               : one-cycle pulse when red/green/blue update
//   busy                    : high from accepted start until after rgb_valid
// Build option: COLOR_MEASURE_AUTO_EN makes the sequencer free-run (restart
// from SET_R after every DONE while wb_ready stays high).
module color_measure
  import color_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freq,
  input  logic        wb_ready,
  input  logic [31:0] R_time,
  input  logic [31:0] G_time,
  input  logic [31:0] B_time,
  input  logic        start,
  output logic [1:0]  filter_select,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        rgb_valid,
  output logic        busy
);

  // The shared down-counter is loaded with (length - 1) on entry to a state
  // and the state is left in the cycle it reads zero.
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [7:0]  pulse_reg, pulse_next, pulse_inc;
  logic [7:0]  shadow_reg [3];
  logic [7:0]  shadow_next [3];
  logic [7:0]  red_reg, red_next;
  logic [7:0]  green_reg, green_next;
  logic [7:0]  blue_reg, blue_next;
  logic        rgb_valid_reg, rgb_valid_next;
  logic        busy_reg, busy_next;
  logic        rise_pulse;

  // Per-channel view of the current state.
  logic [1:0]  ch;
  logic [31:0] t_sel;
  state_t      cnt_state;
  state_t      after_state;
  logic [31:0] after_load;

  freq_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_freq_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .freq       (freq),
    .rise_pulse (rise_pulse)
  );

  always_comb begin
    ch          = 2'd0;
    t_sel       = R_time;
    cnt_state   = CNT_R;
    after_state = SET_G;
    case (state_reg)
      SET_G, CNT_G: begin
        ch          = 2'd1;
        t_sel       = G_time;
        cnt_state   = CNT_G;
        after_state = SET_B;
      end
      SET_B, CNT_B: begin
        ch          = 2'd2;
        t_sel       = B_time;
        cnt_state   = CNT_B;
        after_state = DONE;
      end
      default: ;
    endcase
  end

  assign after_load = (after_state == DONE) ? 32'd0 : SETTLE_LOAD;
  assign pulse_inc  = sat_inc(pulse_reg, rise_pulse);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pulse_next     = pulse_reg;
    shadow_next    = shadow_reg;
    red_next       = red_reg;
    green_next     = green_reg;
    blue_next      = blue_reg;
    rgb_valid_next = 1'b0;

    if ((state_reg != IDLE) && !wb_ready) begin
      // Calibration lost: drop the run, keep the last published colour.
      state_next = IDLE;
      cnt_next   = 32'd0;
      pulse_next = 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && wb_ready) begin
            state_next = SET_R;
            cnt_next   = SETTLE_LOAD;
            pulse_next = 8'd0;
          end
        end
        SET_R, SET_G, SET_B: begin
          pulse_next = 8'd0;
          if (cnt_reg == 32'd0) begin
            // Window length is sampled here, on the way into CNT.
            if (t_sel == 32'd0) begin
              shadow_next[ch] = 8'd0;
              state_next      = after_state;
              cnt_next        = after_load;
            end else begin
              state_next = cnt_state;
              cnt_next   = t_sel - 32'd1;
            end
          end else begin
            cnt_next = cnt_reg - 32'd1;
          end
        end
        CNT_R, CNT_G, CNT_B: begin
          pulse_next = pulse_inc;
          if (cnt_reg == 32'd0) begin
            // Include an edge landing in the final window cycle.
            shadow_next[ch] = pulse_inc;
            state_next      = after_state;
            cnt_next        = after_load;
          end else begin
            cnt_next = cnt_reg - 32'd1;
          end
        end
        DONE: begin
          red_next       = shadow_reg[0];
          green_next     = shadow_reg[1];
          blue_next      = shadow_reg[2];
          rgb_valid_next = 1'b1;
`ifdef COLOR_MEASURE_AUTO_EN
          state_next     = SET_R;
          cnt_next       = SETTLE_LOAD;
`else
          state_next     = IDLE;
`endif
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 32'd0;
        end
      endcase
    end

    // Busy stays up through the rgb_valid cycle and drops one cycle later.
    busy_next = (state_next != IDLE) | rgb_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 32'd0;
      pulse_reg     <= 8'd0;
      red_reg       <= 8'd0;
      green_reg     <= 8'd0;
      blue_reg      <= 8'd0;
      rgb_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pulse_reg     <= pulse_next;
      red_reg       <= red_next;
      green_reg     <= green_next;
      blue_reg      <= blue_next;
      rgb_valid_reg <= rgb_valid_next;
      busy_reg      <= busy_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_reg[gi] <= 8'd0;
        else        shadow_reg[gi] <= shadow_next[gi];
      end
    end
  endgenerate

  always_comb begin
    case (state_reg)
      SET_G, CNT_G: filter_select = FILT_G;
      SET_B, CNT_B: filter_select = FILT_B;
      default:      filter_select = FILT_R;
    endcase
  end

  assign red       = red_reg;
  assign green     = green_reg;
  assign blue      = blue_reg;
  assign rgb_valid = rgb_valid_reg;
  assign busy      = busy_reg;

endmodule
